// File: rtl/conv_3x3_channel_accum_pkg.sv
// Shared definitions for the channel accumulator: default layer geometry,
// FSM state encoding and a counter-width helper.
package conv_3x3_channel_accum_pkg;

  localparam int DEF_DATA_WIDTH      = 32;
  localparam int DEF_IMAGE_WIDTH     = 16;
  localparam int DEF_IMAGE_HEIGHT    = 16;
  localparam int DEF_CHANNEL_NUM_IN  = 512;
  localparam int DEF_CHANNEL_NUM_OUT = 512;
  localparam int DEF_RELU            = 1;

  typedef enum logic [1:0] {
    S_FIRST = 2'd0,
    S_ACC   = 2'd1,
    S_LAST  = 2'd2
  } state_t;

  // Counter width for a modulo-n counter; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_3x3_channel_accum_if.sv
// Partial-sum / bias input stream and finished-pixel output stream.
interface conv_3x3_channel_accum_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] pxl_in;
  logic                  valid_bias_in;
  logic [DATA_WIDTH-1:0] bias_in;
  logic [DATA_WIDTH-1:0] pxl_out;
  logic                  valid_out;
  logic                  ch_done;
  logic                  layer_done;

  modport master (
    output valid_in, pxl_in, valid_bias_in, bias_in,
    input  pxl_out, valid_out, ch_done, layer_done
  );

  modport slave (
    input  valid_in, pxl_in, valid_bias_in, bias_in,
    output pxl_out, valid_out, ch_done, layer_done
  );
endinterface

// File: rtl/conv_3x3_channel_accum_ram.sv
// Per-pixel accumulation buffer: one write port, one read port with a
// registered (1-cycle) read. No reset so it maps onto block RAM.
module conv_3x3_accum_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Synchronous read port.
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/conv_3x3_channel_accum.sv
// Sums CHANNEL_NUM_IN partial maps per output channel pixel-by-pixel, adds
// the channel bias on the first map, saturates every step and emits the
// finished (optionally ReLU-clamped) map while the last partial map streams in.
module conv_3x3_channel_accum
  import conv_3x3_channel_accum_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int IMAGE_WIDTH     = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT    = DEF_IMAGE_HEIGHT,
  parameter int CHANNEL_NUM_IN  = DEF_CHANNEL_NUM_IN,
  parameter int CHANNEL_NUM_OUT = DEF_CHANNEL_NUM_OUT,
  parameter int RELU            = DEF_RELU
) (
  input logic                     clk,
  input logic                     reset,
  conv_3x3_channel_accum_if.slave bus
);

  localparam int IMAGE_SIZE     = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int CNT_WIDTH_PXL  = cnt_width(IMAGE_SIZE);
  localparam int CNT_WIDTH_CIN  = cnt_width(CHANNEL_NUM_IN);
  localparam int CNT_WIDTH_COUT = cnt_width(CHANNEL_NUM_OUT);
  localparam logic [DATA_WIDTH-1:0] DATA_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] DATA_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // A pixel is read two cycles before its write-back lands; with at least
  // four pixels per map the same address is never re-read in that window.
  if (IMAGE_SIZE < 4) begin : g_size_chk
    $error("conv_3x3_channel_accum: IMAGE_SIZE must be >= 4");
  end
  if (CHANNEL_NUM_IN < 1) begin : g_cin_chk
    $error("conv_3x3_channel_accum: CHANNEL_NUM_IN must be >= 1");
  end

  logic [CNT_WIDTH_PXL-1:0]  pxl_cnt_q, pxl_cnt_d;
  logic [CNT_WIDTH_CIN-1:0]  cin_cnt_q, cin_cnt_d;
  logic [CNT_WIDTH_COUT-1:0] cout_cnt_q, cout_cnt_d;
  state_t                    state_q, state_d;
  logic [DATA_WIDTH-1:0]     bias_q;
  logic                      pxl_last, cin_last, cout_last, st_first, st_last;

  logic                      s1_vld_q, s1_first_q, s1_last_q, s1_chend_q, s1_layend_q;
  logic [DATA_WIDTH-1:0]     s1_pxl_q, s1_bias_q;
  logic [CNT_WIDTH_PXL-1:0]  s1_addr_q;

  logic [DATA_WIDTH-1:0]     ram_rdata, addend, sat_val, res_val;
  logic [DATA_WIDTH:0]       sum_ext;
  logic                      ram_we;

  logic [DATA_WIDTH-1:0]     pxl_out_q;
  logic                      valid_out_q, ch_done_q, layer_done_q;

  assign pxl_last  = (pxl_cnt_q == CNT_WIDTH_PXL'(IMAGE_SIZE - 1));
  assign cin_last  = (cin_cnt_q == CNT_WIDTH_CIN'(CHANNEL_NUM_IN - 1));
  assign cout_last = (cout_cnt_q == CNT_WIDTH_COUT'(CHANNEL_NUM_OUT - 1));
  // With a single input channel the first map is also the last one.
  assign st_first  = (state_q == S_FIRST);
  assign st_last   = (state_q == S_LAST) || (CHANNEL_NUM_IN == 1);

  // Next-state for position counters and FSM; everything holds without valid_in.
  always_comb begin
    pxl_cnt_d  = pxl_cnt_q;
    cin_cnt_d  = cin_cnt_q;
    cout_cnt_d = cout_cnt_q;
    state_d    = state_q;
    if (bus.valid_in) begin
      pxl_cnt_d = pxl_last ? '0 : pxl_cnt_q + 1'b1;
      if (pxl_last) begin
        cin_cnt_d = cin_last ? '0 : cin_cnt_q + 1'b1;
        if (cin_last) cout_cnt_d = cout_last ? '0 : cout_cnt_q + 1'b1;
        unique case (state_q)
          S_FIRST: state_d = (CHANNEL_NUM_IN == 1) ? S_FIRST :
                             (CHANNEL_NUM_IN == 2) ? S_LAST : S_ACC;
          S_ACC:   state_d = (cin_cnt_q == CNT_WIDTH_CIN'(CHANNEL_NUM_IN - 2)) ? S_LAST : S_ACC;
          S_LAST:  state_d = S_FIRST;
          default: state_d = S_FIRST;
        endcase
      end
    end
  end

  // Counter, FSM and bias registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pxl_cnt_q  <= '0;
      cin_cnt_q  <= '0;
      cout_cnt_q <= '0;
      state_q    <= S_FIRST;
      bias_q     <= '0;
    end else begin
      pxl_cnt_q  <= pxl_cnt_d;
      cin_cnt_q  <= cin_cnt_d;
      cout_cnt_q <= cout_cnt_d;
      state_q    <= state_d;
      if (bus.valid_bias_in) bias_q <= bus.bias_in;
    end
  end

  // Stage 1 capture: bias is latched here so a same-cycle bias load is not seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q    <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_chend_q  <= 1'b0;
      s1_layend_q <= 1'b0;
      s1_pxl_q    <= '0;
      s1_bias_q   <= '0;
      s1_addr_q   <= '0;
    end else begin
      s1_vld_q    <= bus.valid_in;
      s1_first_q  <= st_first;
      s1_last_q   <= st_last;
      s1_chend_q  <= st_last && pxl_last;
      s1_layend_q <= st_last && pxl_last && cout_last;
      s1_pxl_q    <= bus.pxl_in;
      s1_bias_q   <= bias_q;
      s1_addr_q   <= pxl_cnt_q;
    end
  end

  // Saturating add of the partial sum onto bias or buffered value, then ReLU.
  always_comb begin
    addend  = s1_first_q ? s1_bias_q : ram_rdata;
    sum_ext = {addend[DATA_WIDTH-1], addend} + {s1_pxl_q[DATA_WIDTH-1], s1_pxl_q};
    sat_val = sum_ext[DATA_WIDTH-1:0];
    if (sum_ext[DATA_WIDTH] != sum_ext[DATA_WIDTH-1])
      sat_val = sum_ext[DATA_WIDTH] ? DATA_MIN : DATA_MAX;
    res_val = ((RELU != 0) && sat_val[DATA_WIDTH-1]) ? '0 : sat_val;
  end

  assign ram_we = s1_vld_q && !s1_last_q && !reset;

  conv_3x3_accum_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMAGE_SIZE),
    .ADDR_WIDTH (CNT_WIDTH_PXL)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (s1_addr_q),
    .wdata_i (sat_val),
    .re_i    (bus.valid_in),
    .raddr_i (pxl_cnt_q),
    .rdata_o (ram_rdata)
  );

  // Stage 2 output registers, active only for last-channel pixels.
  always_ff @(posedge clk) begin
    if (reset) begin
      pxl_out_q    <= '0;
      valid_out_q  <= 1'b0;
      ch_done_q    <= 1'b0;
      layer_done_q <= 1'b0;
    end else begin
      valid_out_q  <= s1_vld_q && s1_last_q;
      ch_done_q    <= s1_vld_q && s1_chend_q;
      layer_done_q <= s1_vld_q && s1_layend_q;
      if (s1_vld_q && s1_last_q) pxl_out_q <= res_val;
    end
  end

  assign bus.pxl_out    = pxl_out_q;
  assign bus.valid_out  = valid_out_q;
  assign bus.ch_done    = ch_done_q;
  assign bus.layer_done = layer_done_q;

endmodule

// File: tb/tb_conv_3x3_channel_accum.sv
// Bench for conv_3x3_channel_accum: four 4x4-map instances with different
// channel counts / ReLU settings share one stimulus bus, gated by 'sel'.
module tb_conv_3x3_channel_accum;

  localparam int IMSZ = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld, bvld;
  logic [31:0] pxl, bias;
  int          sel;

  always #5 clk = ~clk;

  conv_3x3_channel_accum_if #(.DATA_WIDTH(32)) if_a ();
  conv_3x3_channel_accum_if #(.DATA_WIDTH(32)) if_b ();
  conv_3x3_channel_accum_if #(.DATA_WIDTH(32)) if_c ();
  conv_3x3_channel_accum_if #(.DATA_WIDTH(32)) if_d ();

  assign if_a.valid_in = vld && (sel == 0);  assign if_a.valid_bias_in = bvld && (sel == 0);
  assign if_b.valid_in = vld && (sel == 1);  assign if_b.valid_bias_in = bvld && (sel == 1);
  assign if_c.valid_in = vld && (sel == 2);  assign if_c.valid_bias_in = bvld && (sel == 2);
  assign if_d.valid_in = vld && (sel == 3);  assign if_d.valid_bias_in = bvld && (sel == 3);
  assign if_a.pxl_in = pxl;  assign if_a.bias_in = bias;
  assign if_b.pxl_in = pxl;  assign if_b.bias_in = bias;
  assign if_c.pxl_in = pxl;  assign if_c.bias_in = bias;
  assign if_d.pxl_in = pxl;  assign if_d.bias_in = bias;

  conv_3x3_channel_accum #(.DATA_WIDTH(32), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4),
    .CHANNEL_NUM_IN(3), .CHANNEL_NUM_OUT(1), .RELU(1)) u_a (.clk(clk), .reset(rst), .bus(if_a));
  conv_3x3_channel_accum #(.DATA_WIDTH(32), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4),
    .CHANNEL_NUM_IN(2), .CHANNEL_NUM_OUT(2), .RELU(1)) u_b (.clk(clk), .reset(rst), .bus(if_b));
  conv_3x3_channel_accum #(.DATA_WIDTH(32), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4),
    .CHANNEL_NUM_IN(2), .CHANNEL_NUM_OUT(2), .RELU(0)) u_c (.clk(clk), .reset(rst), .bus(if_c));
  conv_3x3_channel_accum #(.DATA_WIDTH(32), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4),
    .CHANNEL_NUM_IN(1), .CHANNEL_NUM_OUT(2), .RELU(1)) u_d (.clk(clk), .reset(rst), .bus(if_d));

  logic [3:0]  vo, cd, ld;
  logic [31:0] po [4];
  assign vo = {if_d.valid_out, if_c.valid_out, if_b.valid_out, if_a.valid_out};
  assign cd = {if_d.ch_done, if_c.ch_done, if_b.ch_done, if_a.ch_done};
  assign ld = {if_d.layer_done, if_c.layer_done, if_b.layer_done, if_a.layer_done};
  assign po[0] = if_a.pxl_out;
  assign po[1] = if_b.pxl_out;
  assign po[2] = if_c.pxl_out;
  assign po[3] = if_d.pxl_out;

  int cin_p  [4] = '{3, 2, 2, 1};
  int cout_p [4] = '{1, 2, 2, 2};
  int relu_p [4] = '{1, 1, 0, 1};

  // Reference model: position within the layer and running per-pixel sums.
  int     m_pcnt [4];
  int     m_cin  [4];
  int     m_cout [4];
  longint m_bias [4];
  longint m_acc  [4][IMSZ];

  typedef struct {
    int          sel;
    logic [31:0] val;
    bit          chd;
    bit          lyd;
    int          cyc;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] got_q [$];
  int          chd_cnt, lyd_cnt;
  int          cyc;
  int          checks = 0;
  int          errors = 0;
  exp_t        me;

  // Output monitor: every valid_out must match the next model prediction,
  // including the exact cycle it was due.
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < 4; i++) begin
        if (vo[i]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL spurious_out inst %0d cyc %0d: got valid_out=1 val=%h, required no output", i, cyc, po[i]);
          end else begin
            me = exp_q.pop_front();
            if (me.sel != i || me.val !== po[i] || me.chd !== cd[i] || me.lyd !== ld[i] || me.cyc != cyc) begin
              errors++;
              $display("FAIL out inst %0d cyc %0d: got val=%h ch_done=%0b layer_done=%0b, required inst %0d val=%h ch_done=%0b layer_done=%0b cyc %0d",
                       i, cyc, po[i], cd[i], ld[i], me.sel, me.val, me.chd, me.lyd, me.cyc);
            end
          end
          got_q.push_back(po[i]);
          if (cd[i]) chd_cnt++;
          if (ld[i]) lyd_cnt++;
        end else if (cd[i] || ld[i]) begin
          errors++;
          $display("FAIL stray_done inst %0d cyc %0d: got ch_done=%0b layer_done=%0b, required 0 without valid_out", i, cyc, cd[i], ld[i]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no end of test, required finish within time limit");
    $fatal(1, "timeout");
  end

  function automatic longint sat32(input longint s);
    if (s > 64'sd2147483647) return 64'sd2147483647;
    if (s < -64'sd2147483648) return -64'sd2147483648;
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pcnt[i] = 0; m_cin[i] = 0; m_cout[i] = 0; m_bias[i] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_step(input logic [31:0] v);
    int     s = sel;
    int     p = m_pcnt[s];
    longint a, o;
    exp_t   e;
    if (m_cin[s] == 0) a = sat32(longint'($signed(v)) + m_bias[s]);
    else               a = sat32(m_acc[s][p] + longint'($signed(v)));
    if (m_cin[s] == cin_p[s] - 1) begin
      o = (relu_p[s] != 0 && a < 0) ? 64'sd0 : a;
      e.sel = s; e.val = o[31:0]; e.chd = (p == IMSZ - 1);
      e.lyd = (p == IMSZ - 1) && (m_cout[s] == cout_p[s] - 1);
      e.cyc = cyc + 2;
      exp_q.push_back(e);
    end else begin
      m_acc[s][p] = a;
    end
    m_pcnt[s]++;
    if (m_pcnt[s] == IMSZ) begin
      m_pcnt[s] = 0;
      m_cin[s]++;
      if (m_cin[s] == cin_p[s]) begin
        m_cin[s] = 0;
        m_cout[s]++;
        if (m_cout[s] == cout_p[s]) m_cout[s] = 0;
      end
    end
  endtask

  task automatic send_pix(input logic [31:0] v, input bit wb, input logic [31:0] b);
    @(negedge clk);
    vld = 1'b1; pxl = v; bvld = wb; bias = b;
    model_step(v);
    if (wb) m_bias[sel] = longint'($signed(b));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vld = 1'b0; bvld = 1'b0;
    end
  endtask

  task automatic load_bias(input logic [31:0] b);
    @(negedge clk);
    vld = 1'b0; bvld = 1'b1; bias = b;
    m_bias[sel] = longint'($signed(b));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      vld = 1'b0; bvld = 1'b0;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d outputs still missing, required 0", exp_q.size());
      exp_q.delete();
    end
    idle(2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; vld = 1'b0; bvld = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_obs();
    got_q.delete();
    chd_cnt = 0;
    lyd_cnt = 0;
  endtask

  task automatic check_eq(input string name, input longint got, input longint req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // 3 in-channels, bias 10, in-ch k pixel p = p+k -> 3p+13.
  task automatic run_t1(input string tag);
    sel = 0;
    clear_obs();
    load_bias(32'd10);
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < IMSZ; p++) send_pix(32'(p + k), 1'b0, '0);
    drain();
    check_eq({tag, "_count"}, got_q.size(), IMSZ);
    for (int p = 0; p < IMSZ && p < got_q.size(); p++)
      check_eq($sformatf("%s_pix%0d", tag, p), longint'(got_q[p]), 3 * p + 13);
    check_eq({tag, "_ch_done"}, chd_cnt, 1);
    check_eq({tag, "_layer_done"}, lyd_cnt, 1);
  endtask

  typedef struct {
    int          sel;
    logic [31:0] b;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [6];
  logic [31:0] dat  [64];
  logic [31:0] bs   [2];
  logic [31:0] cont_q [$];
  int          cont_chd, bad;

  initial begin
    vecs[0] = '{1, 32'h0000_0020, 32'h7FFF_FFF0, 32'h7FFF_FFF0, 32'h7FFF_FFFF};
    vecs[1] = '{1, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
    vecs[2] = '{2, 32'h0000_0020, 32'h7FFF_FFF0, 32'h7FFF_FFF0, 32'h7FFF_FFFF};
    vecs[3] = '{2, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    vecs[4] = '{1, 32'h0000_0000, 32'hFFFF_FFFB, 32'h0000_0002, 32'h0000_0000};
    vecs[5] = '{2, 32'h0000_0000, 32'hFFFF_FFFB, 32'h0000_0002, 32'hFFFF_FFFD};

    rst = 1'b1; vld = 1'b0; bvld = 1'b0; pxl = '0; bias = '0; sel = 0;
    model_reset();
    clear_obs();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("reset_pxl_out%0d", i), longint'(po[i]), 0);
      check_eq($sformatf("reset_flags%0d", i), longint'({vo[i], cd[i], ld[i]}), 0);
    end
    rst = 1'b0;

    run_t1("t1");

    // Saturation and ReLU vectors on the two 2-in-channel instances.
    for (int v = 0; v < 6; v++) begin
      idle(4);
      sel = vecs[v].sel;
      clear_obs();
      load_bias(vecs[v].b);
      for (int p = 0; p < IMSZ; p++) send_pix(vecs[v].in0, 1'b0, '0);
      for (int p = 0; p < IMSZ; p++) send_pix(vecs[v].in1, 1'b0, '0);
      drain();
      check_eq($sformatf("vec%0d_count", v), got_q.size(), IMSZ);
      bad = 0;
      foreach (got_q[j]) if (got_q[j] !== vecs[v].exp) bad++;
      check_eq($sformatf("vec%0d_wrong_values", v), bad, 0);
      if (got_q.size() > 0)
        check_eq($sformatf("vec%0d_value", v), longint'(got_q[0]), longint'(vecs[v].exp));
    end

    // Continuous vs gapped stream of identical random data.
    for (int i = 0; i < 64; i++) dat[i] = $urandom;
    bs[0] = $urandom; bs[1] = $urandom_range(100);
    for (int run = 0; run < 2; run++) begin
      do_reset();
      sel = 1;
      clear_obs();
      for (int o = 0; o < 2; o++) begin
        load_bias(bs[o]);
        for (int i = 0; i < 32; i++) begin
          if (run == 1 && $urandom_range(1) == 1) idle(1);
          send_pix(dat[o * 32 + i], 1'b0, '0);
        end
      end
      drain();
      if (run == 0) begin
        cont_q = got_q;
        cont_chd = chd_cnt;
        check_eq("cont_layer_done", lyd_cnt, 1);
      end
    end
    check_eq("gap_count", got_q.size(), cont_q.size());
    check_eq("gap_ch_done", chd_cnt, cont_chd);
    bad = 0;
    foreach (cont_q[j]) if (j < got_q.size() && got_q[j] !== cont_q[j]) bad++;
    check_eq("gap_vs_cont_values", bad, 0);

    // Single input channel: output = p + bias.
    do_reset();
    sel = 3;
    clear_obs();
    load_bias(32'd7);
    for (int o = 0; o < 2; o++)
      for (int p = 0; p < IMSZ; p++) send_pix(32'(p), 1'b0, '0);
    drain();
    check_eq("cin1_count", got_q.size(), 2 * IMSZ);
    for (int j = 0; j < 2 * IMSZ && j < got_q.size(); j += 5)
      check_eq($sformatf("cin1_pix%0d", j), longint'(got_q[j]), (j % IMSZ) + 7);
    check_eq("cin1_ch_done", chd_cnt, 2);
    check_eq("cin1_layer_done", lyd_cnt, 1);

    // Reset in the middle of in-channel 1, then a full rerun.
    do_reset();
    sel = 0;
    clear_obs();
    load_bias(32'd99);
    for (int p = 0; p < IMSZ + 5; p++) send_pix(32'(3 * p + 1), 1'b0, '0);
    do_reset();
    idle(3);
    check_eq("mid_reset_no_output", got_q.size(), 0);
    run_t1("t6");

    // Random streams with gaps and bias loads, some coinciding with pixels.
    for (int s = 0; s < 4; s++) begin
      idle(4);
      sel = s;
      for (int n = 0; n < cin_p[s] * cout_p[s] * IMSZ + 20; n++) begin
        if ($urandom_range(3) == 0) idle(1);
        if ($urandom_range(15) == 0) load_bias($urandom);
        send_pix(($urandom_range(1) == 1) ? $urandom : 32'($urandom_range(200)) - 32'd100,
                 $urandom_range(9) == 0, $urandom_range(1000));
      end
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
